// File: rtl/counter_loader.sv
// counter_loader: FIFO of load values handed one at a time to a downstream counter; ld one cycle after IDLE sees data, then WAIT for val.
// Backpressure: in_ready = !full, offers while full are dropped; optional watchdog on WAIT under `LOADER_TIMEOUT_EN.

module counter_loader_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  output logic                   push_rdy,
  input  logic                   pop_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign push_rdy = (level != (AW+1)'(DEPTH));
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && (level != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module counter_loader #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   ld,
  output logic [7:0]             data,
  input  logic                   val,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             done_cnt,
  output logic                   err
);
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] head_dat;
  logic       pop_vld;
  logic       wd_expire;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("counter_loader: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("counter_loader: TIMEOUT must be in 1..255");
  end

  assign pop_vld = (state == ST_LOAD);

  counter_loader_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (in_valid),
    .push_dat (in_data),
    .push_rdy (in_ready),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .level    (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (level != '0) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_WAIT;
      ST_WAIT: if (val || wd_expire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ld   = 1'b0;
    busy = 1'b0;
    if (state == ST_LOAD) ld   = 1'b1;
    if (state != ST_IDLE) busy = 1'b1;
  end

  // Capture the head on the way into LOAD so data is valid with ld and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        data <= '0;
    else if (state == ST_IDLE && state_nxt == ST_LOAD) data <= head_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        done_cnt <= '0;
    else if (state == ST_WAIT && val)  done_cnt <= done_cnt + 8'd1;
  end

`ifdef LOADER_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wd <= '0;
    else if (state == ST_LOAD)   wd <= '0;
    else if (state == ST_WAIT)   wd <= wd + 8'd1;
  end

  // val arriving on the last permitted cycle wins over the abort.
  assign wd_expire = (state == ST_WAIT) && !val && (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err <= 1'b0;
    else if (wd_expire) err <= 1'b1;
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif
endmodule

// File: tb/tb_counter_loader.sv
// Scoreboard bench for counter_loader: accepted pushes queue expected load values, each ld pulse pops one.
module tb_counter_loader;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 10;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic [7:0]             in_data = 8'h00;
  logic                   val = 1'b0;
  logic                   in_ready;
  logic                   ld;
  logic [7:0]             data;
  logic                   busy;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             done_cnt;
  logic                   err;

  counter_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ld       (ld),
    .data     (data),
    .val      (val),
    .busy     (busy),
    .level    (level),
    .done_cnt (done_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         ld_cnt = 0;
  int         cyc = 0;
  int         last_ld = -100;
  int         exp_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Pop before push: an entry accepted this cycle cannot be the head being loaded.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (ld) begin
        ld_cnt++;
        check("ld_gap", (cyc - last_ld >= 2) ? 32'd1 : 32'd0, 32'd1);
        last_ld = cyc;
        if (exp_q.size() == 0) check("ld_unexpected", exp_q.size(), 32'd1);
        else                   check("ld_data", data, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ld();
    int n = 0;
    while (ld !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (ld !== 1'b1) check("ld_wait", ld, 32'd1);
  endtask

  task automatic ack_load();
    wait_ld();
    step();
    val = 1'b1;
    step();
    val = 1'b0;
    exp_done++;
  endtask

  task automatic push_one(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 32'd1);
    check({tag, "_ld"},       ld,       32'd0);
    check({tag, "_data"},     data,     32'd0);
    check({tag, "_busy"},     busy,     32'd0);
    check({tag, "_level"},    level,    32'd0);
    check({tag, "_done"},     done_cnt, 32'd0);
    check({tag, "_err"},      err,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1);
  end

  initial begin
    int ld_snap;
    int n;

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Single load: one IDLE cycle, then LOAD; val two cycles after ld.
    push_one(8'h5A);
    check("lat_idle_ld", ld, 32'd0);
    check("lat_level", level, 32'd1);
    check("lat_busy", busy, 32'd0);
    step();
    check("lat_ld", ld, 32'd1);
    check("lat_data", data, 32'h5A);
    check("lat_busy_load", busy, 32'd1);
    step();
    check("hold_ld", ld, 32'd0);
    check("hold_data", data, 32'h5A);
    check("hold_level", level, 32'd0);
    step();
    val = 1'b1;
    step();
    val = 1'b0;
    exp_done++;
    check("single_done", done_cnt, 32'd1);
    check("single_busy", busy, 32'd0);

    // val outside WAIT is ignored.
    val = 1'b1;
    repeat (2) step();
    val = 1'b0;
    check("val_idle_done", done_cnt, 8'(exp_done));
    push_one(8'h11);
    step();
    check("val_load_ld", ld, 32'd1);
    val = 1'b1;
    step();
    val = 1'b0;
    check("val_load_done", done_cnt, 8'(exp_done));
    check("val_load_busy", busy, 32'd1);
    val = 1'b1;
    step();
    val = 1'b0;
    exp_done++;
    check("val_wait_done", done_cnt, 8'(exp_done));

    // Fill with FSM parked in WAIT; the sixth offer hits a full queue.
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'hA0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("fill_level", level, 32'd4);
    check("fill_in_ready", in_ready, 32'd0);
    val = 1'b1;
    step();
    val = 1'b0;
    exp_done++;
    repeat (4) ack_load();
    check("fill_drained", level, 32'd0);
    check("fill_sb_empty", exp_q.size(), 32'd0);
    check("fill_in_ready_back", in_ready, 32'd1);

    // Push during the LOAD pop at level 2.
    in_valid = 1'b1;
    in_data  = 8'hB0;
    step();
    in_data  = 8'hB1;
    step();
    check("pp_ld", ld, 32'd1);
    check("pp_level_before", level, 32'd2);
    in_data  = 8'hB2;
    step();
    in_valid = 1'b0;
    check("pp_level_after", level, 32'd2);
    val = 1'b1;
    step();
    val = 1'b0;
    exp_done++;
    repeat (2) ack_load();
    check("pp_done", done_cnt, 8'(exp_done));

    push_one(8'hC0);
    push_one(8'hC1);
    step();
`ifdef LOADER_TIMEOUT_EN
    n = 0;
    while (busy && n < 30) begin
      step();
      n++;
    end
    check("wd_cycles", n, 32'd10);
    check("wd_err", err, 32'd1);
    check("wd_done", done_cnt, 8'(exp_done));
    ack_load();
    check("wd_err_sticky", err, 32'd1);
`else
    n = 0;
    repeat (20) step();
    check("nowd_busy", busy, 32'd1);
    check("nowd_err", err, 32'd0);
    check("nowd_level", level, 32'd1);
    val = 1'b1;
    step();
    val = 1'b0;
    exp_done++;
    ack_load();
`endif
    check("c_sb_empty", exp_q.size(), 32'd0);

    // done_cnt wraps after 256 completions counted from here.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_done = 0;
    while (exp_done < 255) begin
      push_one(8'(exp_done));
      ack_load();
    end
    check("wrap_255", done_cnt, 32'd255);
    push_one(8'hEE);
    ack_load();
    check("wrap_0", done_cnt, 32'd0);

    // Reset while in WAIT with three entries queued.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hD0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("mid_level", level, 32'd3);
    check("mid_busy", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    ld_snap = ld_cnt;
    repeat (2) step();
    rst_n = 1'b1;
    val = 1'b1;
    repeat (6) step();
    val = 1'b0;
    check("post_rst_no_ld", ld_cnt, ld_snap);
    check("post_rst_level", level, 32'd0);

    // Push on the first edge after release.
    rst_n = 1'b0;
    #2;
    in_valid = 1'b1;
    in_data  = 8'hE5;
    rst_n    = 1'b1;
    step();
    in_valid = 1'b0;
    exp_done = 0;
    check("release_push_level", level, 32'd1);
    ack_load();
    check("release_done", done_cnt, 32'd1);
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter_loader.md
COUNTER_LOADER -- requirements
Module: counter_loader

Interface
REQ-001 Parameter DEPTH, 4, load-value queue entries (power of 2, 2..16).
REQ-002 Parameter TIMEOUT, 255, max WAIT cycles before abort (only with LOADER_TIMEOUT_EN).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream offers in_data.
REQ-006 in_data  input  8  load value to queue.
REQ-007 in_ready  output  1  queue can accept; equals !full.
REQ-008 ld  output  1  load strobe to downstream counter.
REQ-009 data  output  8  load value to downstream counter, meaningful while ld=1.
REQ-010 val  input  1  counter done indication; loader consumes it only in WAIT.
REQ-011 busy  output  1  FSM not in IDLE.
REQ-012 level  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-013 done_cnt  output  8  completed load operations.
REQ-014 err  output  1  sticky timeout flag (tied 0 without LOADER_TIMEOUT_EN).

Function
REQ-015 Queue SHALL be a FIFO; push when in_valid && in_ready; head popped only in LOAD.
REQ-016 in_ready SHALL be low when level==DEPTH; in_valid while full SHALL be dropped without state change.
REQ-017 Push and pop in the same cycle SHALL leave level unchanged and preserve order.
REQ-018 FSM states IDLE, LOAD, WAIT; IDLE->LOAD when level!=0; LOAD->WAIT unconditionally; WAIT->IDLE on val=1.
REQ-019 ld SHALL be 1 for exactly one cycle, only while in LOAD, with data = queue head in that same cycle.
REQ-020 Latency: value pushed at edge N into empty queue with FSM in IDLE SHALL appear with ld=1 in cycle N+1 to N+2 (one IDLE cycle, then LOAD).
REQ-021 val in IDLE or LOAD SHALL be ignored; val in WAIT SHALL increment done_cnt by 1 (mod 256, 255->0).
REQ-022 Back-to-back loads: WAIT->IDLE->LOAD minimum 2 cycles between successive ld pulses.
REQ-023 data SHALL hold its last driven value when ld=0.
REQ-024 level SHALL never exceed DEPTH nor underflow; pointers wrap modulo DEPTH.

Reset
REQ-025 rst_n=0 SHALL immediately force: FSM IDLE, queue empty, level=0, ld=0, data=0, busy=0, done_cnt=0, err=0, in_ready=1.
REQ-026 Reset mid-operation (LOAD or WAIT) SHALL discard queued and in-flight values; no ld after release until a new push.
REQ-027 Deassertion of rst_n SHALL be honoured on the next clk edge; first push allowed that edge.

Configuration
REQ-028 Macro LOADER_TIMEOUT_EN defined: 8-bit watchdog counts WAIT cycles; reaching TIMEOUT without val SHALL set err=1 (sticky until reset), return FSM to IDLE, done_cnt unchanged.
REQ-029 Macro LOADER_TIMEOUT_EN undefined: no watchdog, WAIT holds indefinitely, err constant 0.
REQ-030 Watchdog SHALL clear on entering WAIT; val on the timeout cycle SHALL count as completion, err not set.

Verification
REQ-031 Single load: push 8'h5A, val=1 two cycles after ld -> one ld pulse with data=8'h5A, done_cnt=1, busy returns 0.
REQ-032 Fill: push 4 values with val held 0 -> in_ready=0 after 4th, 5th value dropped, level=4; then release val -> ld data in push order.
REQ-033 Simultaneous push/pop at level=2 -> level stays 2, order preserved.
REQ-034 done_cnt wrap: 256 completed loads -> done_cnt=0.
REQ-035 Reset in WAIT with level=3 -> all outputs at reset values, no ld after release.
REQ-036 LOADER_TIMEOUT_EN, TIMEOUT=10, val held 0 -> err=1 after 10 WAIT cycles, FSM IDLE, next queued value loaded.
